// File: rtl/mem_stage.sv
// mem_stage: registers EX results, runs loads/stores over a req/ack data port,
// steers byte/half lanes, extends load data and flags misaligned accesses.
module mem_stage #(
    parameter int MEM_CTRL_W = 5,
    parameter int REG_WR_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PIPELINE_FLUSH,
    input  logic                  PIPELINE_READY,
    output logic                  PIPELINE_VALID,
    input  logic [REG_WR_W-1:0]   s_reg_write_bus_i,
    input  logic [MEM_CTRL_W-1:0] s_mem_contral_bus_i,
    input  logic [31:0]           ex_result_i,
    input  logic [31:0]           rt_bypass_i,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [31:0]           dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic                  dmem_ack,
    input  logic [31:0]           dmem_rdata,
    output logic [REG_WR_W-1:0]   s_reg_write_bus,
    output logic [31:0]           wb_data,
    output logic                  s_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                state_q, state_d;
    logic [MEM_CTRL_W-1:0] ctrl_q;
    logic [REG_WR_W-1:0]   rwb_q;
    logic [31:0]           addr_q, rt_q, wb_q;
    logic                  mis_q;

    // READY is ignored while an access is outstanding so the access always completes
    logic latch;
    assign latch = PIPELINE_READY && (state_q != REQ);

    // Misalignment of the incoming op; only meaningful for memory ops
    logic       in_en, in_mis;
    logic [1:0] in_size, in_a;
    assign in_en   = s_mem_contral_bus_i[4];
    assign in_size = s_mem_contral_bus_i[1:0];
    assign in_a    = ex_result_i[1:0];
    assign in_mis  = in_en && ((in_size == 2'b11) ||
                               (in_size == 2'b01 && in_a[0]) ||
                               (in_size == 2'b10 && in_a != 2'b00));

    // Next-state: REQ only for aligned memory ops, held until ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:     if (dmem_ack) state_d = DONE;
            default: if (latch) begin
                if (PIPELINE_FLUSH)        state_d = IDLE;
                else if (in_en && !in_mis) state_d = REQ;
                else                       state_d = DONE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Lane steering of the registered op
    logic [1:0]  size_q, a_q;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
    assign size_q = ctrl_q[1:0];
    assign a_q    = addr_q[1:0];

    // Load extraction and sign/zero extension
    always_comb begin
        ld_b = dmem_rdata[7:0];
        case (a_q)
            2'd1:    ld_b = dmem_rdata[15:8];
            2'd2:    ld_b = dmem_rdata[23:16];
            2'd3:    ld_b = dmem_rdata[31:24];
            default: ld_b = dmem_rdata[7:0];
        endcase
        ld_h = a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   ld_data = ctrl_q[2] ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'b01:   ld_data = ctrl_q[2] ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Store data replication and byte enables (no enables on loads)
    always_comb begin
        dmem_wstrb = 4'b0000;
        case (size_q)
            2'b00:   dmem_wdata = {4{rt_q[7:0]}};
            2'b01:   dmem_wdata = {2{rt_q[15:0]}};
            default: dmem_wdata = rt_q;
        endcase
        if (ctrl_q[3]) begin
            case (size_q)
                2'b00:   dmem_wstrb = 4'b0001 << a_q;
                2'b01:   dmem_wstrb = a_q[1] ? 4'b1100 : 4'b0011;
                default: dmem_wstrb = 4'b1111;
            endcase
        end
    end

    // Stage registers: capture on latch, bubble on flush, load data on ack
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            rwb_q  <= '0;
            addr_q <= '0;
            rt_q   <= '0;
            wb_q   <= '0;
            mis_q  <= 1'b0;
        end else if (latch) begin
            if (PIPELINE_FLUSH) begin
                ctrl_q <= '0;
                rwb_q  <= '0;
                mis_q  <= 1'b0;
            end else begin
                ctrl_q <= s_mem_contral_bus_i;
                rwb_q  <= {s_reg_write_bus_i[REG_WR_W-1] & ~in_mis,
                           s_reg_write_bus_i[REG_WR_W-2:0]};
                addr_q <= ex_result_i;
                rt_q   <= rt_bypass_i;
                wb_q   <= ex_result_i;
                mis_q  <= in_mis;
            end
        end else if (state_q == REQ && dmem_ack && !ctrl_q[3]) begin
            wb_q <= ld_data;
        end
    end

    assign dmem_req        = (state_q == REQ);
    assign PIPELINE_VALID  = (state_q != REQ);
    assign dmem_we         = ctrl_q[3];
    assign dmem_addr       = {addr_q[31:2], 2'b00};
    assign s_reg_write_bus = rwb_q;
    assign wb_data         = wb_q;
    assign s_misalign      = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level reference model, random memory
// responder, directed scenarios and a randomized op stream.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PIPELINE_FLUSH = 1'b0, PIPELINE_READY = 1'b0, PIPELINE_VALID;
    logic [5:0]  s_reg_write_bus_i = '0, s_reg_write_bus;
    logic [4:0]  s_mem_contral_bus_i = '0;
    logic [31:0] ex_result_i = '0, rt_bypass_i = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0, s_misalign;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, wb_data;
    logic [3:0]  dmem_wstrb;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .PIPELINE_FLUSH(PIPELINE_FLUSH), .PIPELINE_READY(PIPELINE_READY),
        .PIPELINE_VALID(PIPELINE_VALID),
        .s_reg_write_bus_i(s_reg_write_bus_i), .s_mem_contral_bus_i(s_mem_contral_bus_i),
        .ex_result_i(ex_result_i), .rt_bypass_i(rt_bypass_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .s_reg_write_bus(s_reg_write_bus), .wb_data(wb_data), .s_misalign(s_misalign)
    );

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- specification-level helpers ----------------
    function automatic logic f_mis(input logic [4:0] c, input logic [31:0] a);
        int sz = int'(c[1:0]);
        int lo = int'(a[1:0]);
        if (!c[4]) return 1'b0;
        if (sz == 3) return 1'b1;
        if (sz == 1) return (lo % 2) != 0;
        if (sz == 2) return lo != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] f_wstrb(input logic [4:0] c, input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (!c[3]) return 4'b0000;
        case (c[1:0])
            2'b00:   return 4'(1 << lo);
            2'b01:   return (lo >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [4:0] c, input logic [31:0] rt);
        case (c[1:0])
            2'b00:   return (rt & 32'hFF) * 32'h0101_0101;
            2'b01:   return (rt & 32'hFFFF) * 32'h0001_0001;
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int lo = int'(a[1:0]);
        case (sz)
            2'b00: begin
                v = (d >> (8 * lo)) & 32'hFF;
                return uns ? v : (v ^ 32'h80) - 32'h80;
            end
            2'b01: begin
                v = (d >> (8 * lo)) & 32'hFFFF;
                return uns ? v : (v ^ 32'h8000) - 32'h8000;
            end
            default: return d;
        endcase
    endfunction

    // ---------------- reference model (one op in flight) ----------------
    logic        m_pend, m_mis;
    logic [5:0]  m_rwb;
    logic [31:0] m_wb, m_ex, m_rt;
    logic [4:0]  m_ctrl;

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0; m_mis <= 1'b0; m_rwb <= '0; m_wb <= '0; m_ctrl <= '0;
        end else if (m_pend) begin
            if (dmem_ack) begin
                m_pend <= 1'b0;
                if (!m_ctrl[3]) m_wb <= f_load(dmem_rdata, m_ex, m_ctrl[1:0], m_ctrl[2]);
            end
        end else if (PIPELINE_READY) begin
            if (PIPELINE_FLUSH) begin
                m_ctrl <= '0; m_rwb <= '0; m_mis <= 1'b0;
            end else begin
                m_ctrl <= s_mem_contral_bus_i;
                m_ex   <= ex_result_i;
                m_rt   <= rt_bypass_i;
                m_wb   <= ex_result_i;
                m_mis  <= f_mis(s_mem_contral_bus_i, ex_result_i);
                m_rwb  <= f_mis(s_mem_contral_bus_i, ex_result_i) ?
                          (s_reg_write_bus_i & 6'h1F) : s_reg_write_bus_i;
                m_pend <= s_mem_contral_bus_i[4] && !f_mis(s_mem_contral_bus_i, ex_result_i);
            end
        end
    end

    // ---------------- compare process ----------------
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dmem_req", 32'(dmem_req), 32'(m_pend));
            chk("valid", 32'(PIPELINE_VALID), 32'(!m_pend));
            chk("reg_write_bus", 32'(s_reg_write_bus), 32'(m_rwb));
            chk("misalign", 32'(s_misalign), 32'(m_mis));
            if (!m_pend) chk("wb_data", wb_data, m_wb);
            else begin
                chk("dmem_addr", dmem_addr, m_ex & 32'hFFFF_FFFC);
                chk("dmem_we", 32'(dmem_we), 32'(m_ctrl[3]));
                chk("dmem_wstrb", 32'(dmem_wstrb), 32'(f_wstrb(m_ctrl, m_ex)));
                if (m_ctrl[3]) chk("dmem_wdata", dmem_wdata, f_wdata(m_ctrl, m_rt));
            end
        end
    end

    // ---------------- memory responder ----------------
    int          force_delay = 0;
    bit          ack_force = 1'b0, spurious_en = 1'b0, busy = 1'b0;
    int          wcnt = 0;
    logic [31:0] mem [int];

    always @(negedge clk) begin
        if (ack_force) begin
            dmem_ack = 1'b1; dmem_rdata = $urandom;
        end else if (dmem_req) begin
            if (!busy) begin
                busy = 1'b1;
                wcnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
            end
            if (wcnt == 0) begin
                dmem_ack = 1'b1;
                busy = 1'b0;
                if (dmem_we) begin
                    logic [31:0] w;
                    w = mem.exists(int'(dmem_addr)) ? mem[int'(dmem_addr)] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (dmem_wstrb[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
                    mem[int'(dmem_addr)] = w;
                    dmem_rdata = $urandom;
                end else begin
                    dmem_rdata = mem.exists(int'(dmem_addr)) ? mem[int'(dmem_addr)] : $urandom;
                end
            end else begin
                wcnt--;
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
            end
        end else begin
            busy = 1'b0;
            dmem_ack = spurious_en && ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
        end
    end

    // ---------------- stimulus ----------------
    bit          rand_err = 1'b0;
    logic        f_req;
    logic [31:0] f_addr, f_wdat;
    logic [3:0]  f_strb;

    // Issue one op (READY for one edge), wait out its access; lowc = cycles VALID low
    task automatic do_op(input bit flush, input logic [4:0] c, input logic [5:0] rwb,
                         input logic [31:0] ex, input logic [31:0] rt, output int lowc);
        PIPELINE_READY = 1'b1; PIPELINE_FLUSH = flush;
        s_mem_contral_bus_i = c; s_reg_write_bus_i = rwb; ex_result_i = ex; rt_bypass_i = rt;
        @(negedge clk);
        PIPELINE_READY = 1'b0; PIPELINE_FLUSH = 1'b0;
        f_req = dmem_req; f_addr = dmem_addr; f_wdat = dmem_wdata; f_strb = dmem_wstrb;
        lowc = 0;
        while (dmem_req && lowc < 40) begin
            lowc++;
            if (rand_err && $urandom_range(0, 2) == 0) begin
                PIPELINE_READY = 1'b1; PIPELINE_FLUSH = 1'($urandom);
                s_mem_contral_bus_i = 5'($urandom); s_reg_write_bus_i = 6'($urandom);
                ex_result_i = $urandom; rt_bypass_i = $urandom;
            end
            @(negedge clk);
            PIPELINE_READY = 1'b0;
        end
        chk("req_released", 32'(dmem_req), 32'h0);
    endtask

    initial begin
        int lc;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_valid", 32'(PIPELINE_VALID), 32'h1);
        chk("rst_rwb", 32'(s_reg_write_bus), 32'h0);
        chk("rst_mis", 32'(s_misalign), 32'h0);
        chk("rst_wb", wb_data, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // ALU op
        do_op(1'b0, 5'b00000, 6'h25, 32'h1234, 32'h0, lc);
        chk("alu_lat", 32'(lc), 32'h0);
        chk("alu_wb", wb_data, 32'h1234);
        chk("alu_model_wb", m_wb, 32'h1234);
        chk("alu_rwb", 32'(s_reg_write_bus), 32'h25);

        // lb / lbu with a 3-cycle memory
        mem[32'h100] = 32'h80FF_0000;
        force_delay = 2;
        do_op(1'b0, 5'b10000, 6'h26, 32'h103, 32'h0, lc);
        chk("lb_low", 32'(lc), 32'd3);
        chk("lb_wb", wb_data, 32'hFFFF_FF80);
        chk("lb_model_wb", m_wb, 32'hFFFF_FF80);
        do_op(1'b0, 5'b10100, 6'h26, 32'h103, 32'h0, lc);
        chk("lbu_wb", wb_data, 32'h0000_0080);

        // sh upper half
        do_op(1'b0, 5'b11001, 6'h00, 32'h102, 32'h0000_ABCD, lc);
        chk("sh_req", 32'(f_req), 32'h1);
        chk("sh_strb", 32'(f_strb), 32'hC);
        chk("sh_wdata", f_wdat, 32'hABCD_ABCD);
        chk("sh_addr", f_addr, 32'h100);
        chk("sh_held", 32'(lc), 32'd3);

        // misaligned lw
        do_op(1'b0, 5'b10010, 6'h23, 32'h102, 32'h0, lc);
        chk("mis_lat", 32'(lc), 32'h0);
        chk("mis_flag", 32'(s_misalign), 32'h1);
        chk("mis_rwb", 32'(s_reg_write_bus), 32'h03);
        chk("mis_valid", 32'(PIPELINE_VALID), 32'h1);

        // flush with lw inputs
        do_op(1'b1, 5'b10010, 6'h27, 32'h104, 32'h0, lc);
        chk("flush_rwb", 32'(s_reg_write_bus), 32'h0);
        chk("flush_noreq", 32'(lc), 32'h0);

        // reset during REQ, late ack ignored
        force_delay = 20;
        PIPELINE_READY = 1'b1; s_mem_contral_bus_i = 5'b10010;
        s_reg_write_bus_i = 6'h29; ex_result_i = 32'h108;
        @(negedge clk);
        PIPELINE_READY = 1'b0;
        chk("rstmid_req_up", 32'(dmem_req), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req_down", 32'(dmem_req), 32'h0);
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(dmem_req), 32'h0);
        chk("late_ack_valid", 32'(PIPELINE_VALID), 32'h1);
        chk("late_ack_wb", wb_data, 32'h0);

        // back-to-back sw / lw with single-cycle memory
        force_delay = 0;
        do_op(1'b0, 5'b11010, 6'h00, 32'h200, 32'hDEAD_BEEF, lc);
        chk("sw_low", 32'(lc), 32'd1);
        do_op(1'b0, 5'b10010, 6'h28, 32'h200, 32'h0, lc);
        chk("lw_low", 32'(lc), 32'd1);
        chk("lw_wb", wb_data, 32'hDEAD_BEEF);

        // randomized stream: random delays, stray acks, READY during REQ
        force_delay = -1; spurious_en = 1'b1; rand_err = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] c;
            c = ($urandom_range(0, 9) < 2) ? {1'b0, 4'($urandom)} : {1'b1, 4'($urandom)};
            do_op($urandom_range(0, 9) == 0, c, 6'($urandom),
                  32'h300 + $urandom_range(0, 31), $urandom, lc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
